aes_gcm_input_framer: RTL and testbench

- Front-end of the AES-GCM pipeline. Sits directly upstream of pipeline stage 1.
- Accepts a 128-bit word stream with a valid/ready handshake and parses each instance in the order key, IV, lengths, AAD blocks, PT blocks.
- Presents one registered block per accepted data beat, using the exact field set stage 1 registers: cipher key, plain text, AAD, IV, instance size, new-instance flag and PT/AAD flag.
- Adds an output valid strobe.

---
 rtl/aes_gcm_input_framer_if.sv | 28 ++
 rtl/aes_gcm_input_framer.sv | 148 ++++++++++++++
 tb/tb_aes_gcm_input_framer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_gcm_input_framer_if.sv
// Stream and block bus between the upstream word source, the input framer and stage 1.
// Bit 0 of every vector is the MSB.
interface aes_gcm_input_framer_if;
    logic [0:127] i_data;
    logic         i_valid;
    logic         o_ready;
    logic         i_abort;
    logic         o_valid;
    logic [0:127] o_cipher_key;
    logic [0:95]  o_iv;
    logic [0:127] o_instance_size;
    logic [0:127] o_aad;
    logic [0:127] o_plain_text;
    logic         o_new_instance;
    logic         o_pt_instance;

    modport slave (
        input  i_data, i_valid, i_abort,
        output o_ready, o_valid, o_cipher_key, o_iv, o_instance_size,
        output o_aad, o_plain_text, o_new_instance, o_pt_instance
    );

    modport master (
        output i_data, i_valid, i_abort,
        input  o_ready, o_valid, o_cipher_key, o_iv, o_instance_size,
        input  o_aad, o_plain_text, o_new_instance, o_pt_instance
    );
endinterface

// File: rtl/aes_gcm_input_framer.sv
// Parses key, IV, lengths, AAD and PT beats of each AES-GCM instance into the
// registered block format consumed by pipeline stage 1.
module aes_gcm_input_framer #(
    parameter bit ZERO_PAD = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    aes_gcm_input_framer_if.slave bus
);
    typedef enum logic [2:0] {StKey, StIv, StLen, StAad, StPt} state_e;

    state_e       state_q, state_d;
    logic         ready_q;
    logic [0:127] key_q, key_d, size_q, size_d, aad_q, aad_d, pt_q, pt_d;
    logic [0:95]  iv_q, iv_d;
    logic [56:0]  aad_cnt_q, aad_cnt_d, pt_cnt_q, pt_cnt_d;
    logic         valid_q, valid_d, new_q, new_d, pt_flag_q, pt_flag_d, first_q, first_d;
    logic         accept;
    logic [56:0]  aad_blocks, pt_blocks;

    // Keeps the first r bits of the final block of a section when r != 0.
    function automatic logic [0:127] tail_mask(input logic last, input logic [6:0] r);
        logic [0:127] ones;
        ones = '1;
        return (ZERO_PAD && last && (r != 7'd0)) ? ~(ones >> r) : ones;
    endfunction

    assign accept     = bus.i_valid & ready_q;
    assign aad_blocks = bus.i_data[0:56] + 57'(|bus.i_data[57:63]);
    assign pt_blocks  = bus.i_data[64:120] + 57'(|bus.i_data[121:127]);

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        iv_d      = iv_q;
        size_d    = size_q;
        aad_d     = aad_q;
        pt_d      = pt_q;
        aad_cnt_d = aad_cnt_q;
        pt_cnt_d  = pt_cnt_q;
        pt_flag_d = pt_flag_q;
        first_d   = first_q;
        valid_d   = 1'b0;
        new_d     = 1'b0;

        if (bus.i_abort) begin
            state_d   = StKey;
            aad_cnt_d = '0;
            pt_cnt_d  = '0;
            first_d   = 1'b0;
        end else if (accept) begin
            unique case (state_q)
                StKey: begin
                    key_d   = bus.i_data;
                    state_d = StIv;
                end
                StIv: begin
                    iv_d    = bus.i_data[0:95];
                    state_d = StLen;
                end
                StLen: begin
                    size_d    = bus.i_data;
                    aad_cnt_d = aad_blocks;
                    pt_cnt_d  = pt_blocks;
                    first_d   = 1'b1;
                    if (aad_blocks != '0) begin
                        state_d = StAad;
                    end else if (pt_blocks != '0) begin
                        state_d = StPt;
                    end else begin
                        // Empty instance still produces one marker block for stage 1.
                        valid_d   = 1'b1;
                        new_d     = 1'b1;
                        pt_flag_d = 1'b1;
                        pt_d      = '0;
                        first_d   = 1'b0;
                        state_d   = StKey;
                    end
                end
                StAad: begin
                    aad_d     = bus.i_data & tail_mask(aad_cnt_q == 57'd1, size_q[57:63]);
                    valid_d   = 1'b1;
                    new_d     = first_q;
                    first_d   = 1'b0;
                    pt_flag_d = 1'b0;
                    aad_cnt_d = aad_cnt_q - 57'd1;
                    if (aad_cnt_q == 57'd1) begin
                        state_d = (pt_cnt_q != '0) ? StPt : StKey;
                    end
                end
                StPt: begin
                    pt_d      = bus.i_data & tail_mask(pt_cnt_q == 57'd1, size_q[121:127]);
                    valid_d   = 1'b1;
                    new_d     = first_q;
                    first_d   = 1'b0;
                    pt_flag_d = 1'b1;
                    pt_cnt_d  = pt_cnt_q - 57'd1;
                    if (pt_cnt_q == 57'd1) begin
                        state_d = StKey;
                    end
                end
                default: state_d = StKey;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StKey;
            ready_q   <= 1'b0;
            key_q     <= '0;
            iv_q      <= '0;
            size_q    <= '0;
            aad_q     <= '0;
            pt_q      <= '0;
            aad_cnt_q <= '0;
            pt_cnt_q  <= '0;
            valid_q   <= 1'b0;
            new_q     <= 1'b0;
            pt_flag_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= 1'b1;
            key_q     <= key_d;
            iv_q      <= iv_d;
            size_q    <= size_d;
            aad_q     <= aad_d;
            pt_q      <= pt_d;
            aad_cnt_q <= aad_cnt_d;
            pt_cnt_q  <= pt_cnt_d;
            valid_q   <= valid_d;
            new_q     <= new_d;
            pt_flag_q <= pt_flag_d;
            first_q   <= first_d;
        end
    end

    assign bus.o_ready         = ready_q;
    assign bus.o_valid         = valid_q;
    assign bus.o_cipher_key    = key_q;
    assign bus.o_iv            = iv_q;
    assign bus.o_instance_size = size_q;
    assign bus.o_aad           = aad_q;
    assign bus.o_plain_text    = pt_q;
    assign bus.o_new_instance  = new_q;
    assign bus.o_pt_instance   = pt_flag_q;
endmodule

// File: tb/tb_aes_gcm_input_framer.sv
// Scoreboard bench: a padded and an unpadded framer share one stimulus stream;
// a negedge monitor pops the expected block for each o_valid.
module tb_aes_gcm_input_framer;
    logic         clk;
    logic         rst;
    logic [127:0] i_data;
    logic         i_valid;
    logic         i_abort;

    aes_gcm_input_framer_if bus0 ();
    aes_gcm_input_framer_if bus1 ();

    assign bus0.i_data  = i_data;
    assign bus0.i_valid = i_valid;
    assign bus0.i_abort = i_abort;
    assign bus1.i_data  = i_data;
    assign bus1.i_valid = i_valid;
    assign bus1.i_abort = i_abort;

    aes_gcm_input_framer #(.ZERO_PAD(1'b1)) dut_pad (.clk(clk), .rst(rst), .bus(bus0));
    aes_gcm_input_framer #(.ZERO_PAD(1'b0)) dut_raw (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [127:0] key;
        logic [95:0]  iv;
        logic [127:0] size;
        logic [127:0] aad;
        logic [127:0] pt;
        logic         nw;
        logic         ptf;
    } exp_t;

    exp_t         sq[2][$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           blk_cnt = 0;
    int           new_cnt = 0;
    logic [127:0] m_key, m_size;
    logic [95:0]  m_iv;
    logic [127:0] m_aad[2];
    logic [127:0] m_pt[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Bit i counted from the MSB; clears every bit at or past position r (r = 0 keeps all).
    function automatic logic [127:0] tb_mask(input logic [127:0] d, input int r);
        for (int i = 0; i < 128; i++) if (r != 0 && i >= r) d[127-i] = 1'b0;
        return d;
    endfunction

    task automatic push_blk(input bit is_pt, input bit nw, input logic [127:0] d0,
                            input logic [127:0] d1);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (is_pt) m_pt[k] = (k == 0) ? d0 : d1;
            else m_aad[k] = (k == 0) ? d0 : d1;
            e.key = m_key; e.iv = m_iv; e.size = m_size;
            e.aad = m_aad[k]; e.pt = m_pt[k]; e.nw = nw; e.ptf = is_pt;
            sq[k].push_back(e);
        end
    endtask

    task automatic mon_one(input int k, input logic nw, input logic ptf, input logic [127:0] key,
                           input logic [127:0] iv, input logic [127:0] size,
                           input logic [127:0] aad, input logic [127:0] pt);
        exp_t e;
        if (sq[k].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d unexpected o_valid: got 1 expected 0", k);
        end else begin
            e = sq[k].pop_front();
            chk($sformatf("dut%0d key", k), key, e.key);
            chk($sformatf("dut%0d iv", k), iv, 128'(e.iv));
            chk($sformatf("dut%0d size", k), size, e.size);
            chk($sformatf("dut%0d aad", k), aad, e.aad);
            chk($sformatf("dut%0d pt", k), pt, e.pt);
            chk($sformatf("dut%0d flags new/pt", k), 128'({nw, ptf}), 128'({e.nw, e.ptf}));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.o_valid) begin
                blk_cnt++;
                if (bus0.o_new_instance) new_cnt++;
                mon_one(0, bus0.o_new_instance, bus0.o_pt_instance, bus0.o_cipher_key,
                        128'(bus0.o_iv), bus0.o_instance_size, bus0.o_aad, bus0.o_plain_text);
            end
            if (bus1.o_valid) begin
                mon_one(1, bus1.o_new_instance, bus1.o_pt_instance, bus1.o_cipher_key,
                        128'(bus1.o_iv), bus1.o_instance_size, bus1.o_aad, bus1.o_plain_text);
            end
        end
    end

    task automatic send(input logic [127:0] d, input bit gaps, input bit abort);
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        i_valid = 1'b1;
        i_data  = d;
        i_abort = abort;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_abort = 1'b0;
    endtask

    task automatic do_instance(input logic [127:0] key, input logic [95:0] iv, input int la,
                               input int lp, input logic [127:0] base, input bit vary,
                               input bit gaps);
        int na, np;
        bit first;
        logic [127:0] d;
        na = (la + 127) / 128;
        np = (lp + 127) / 128;
        first = 1'b1;
        m_key = key;
        send(key, gaps, 1'b0);
        m_iv = iv;
        send({iv, 32'h0BAD_F00D}, gaps, 1'b0);
        m_size = {64'(la), 64'(lp)};
        if (na == 0 && np == 0) push_blk(1'b1, 1'b1, '0, '0);
        send(m_size, gaps, 1'b0);
        for (int k = 0; k < na; k++) begin
            d = vary ? base ^ {4{32'(k)}} : base;
            push_blk(1'b0, first, (k == na - 1) ? tb_mask(d, la % 128) : d, d);
            first = 1'b0;
            send(d, gaps, 1'b0);
        end
        for (int k = 0; k < np; k++) begin
            d = vary ? base ^ {4{32'(k + 16)}} : base;
            push_blk(1'b1, first, (k == np - 1) ? tb_mask(d, lp % 128) : d, d);
            first = 1'b0;
            send(d, gaps, 1'b0);
        end
    endtask

    int b0, n0, blk_nogap, blk_gap;

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_abort = 1'b0; i_data = '0;
        m_key = '0; m_iv = '0; m_size = '0;
        m_aad[0] = '0; m_aad[1] = '0; m_pt[0] = '0; m_pt[1] = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst key", bus0.o_cipher_key, '0);
        chk("rst iv", 128'(bus0.o_iv), '0);
        chk("rst size", bus0.o_instance_size, '0);
        chk("rst aad/pt", bus0.o_aad | bus0.o_plain_text, '0);
        chk("rst ready/valid/new/pt", 128'({bus0.o_ready, bus0.o_valid, bus0.o_new_instance,
                                            bus0.o_pt_instance, bus1.o_ready}), '0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready before first edge", 128'(bus0.o_ready), '0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("ready after release", 128'({bus0.o_ready, bus1.o_ready}), 128'(2'b11));
        @(posedge clk); #1;

        // Full instance: 1 AAD, 2 PT
        do_instance(128'h000102030405060708090A0B0C0D0E0F, 96'hCAFEBABE_CAFEBABE_CAFEBABE,
                    128, 256, 128'h11112222_33334444_55556666_77778888, 1'b1, 1'b0);

        // Partial blocks with all-ones data
        do_instance(128'hA5A5, 96'h1234, 40, 200, '1, 1'b0, 1'b0);
        chk("pad aad", bus0.o_aad, 128'hFFFFFFFFFF0000000000000000000000);
        chk("pad pt", bus0.o_plain_text, 128'hFFFFFFFFFFFFFFFFFF00000000000000);
        chk("raw aad", bus1.o_aad, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF);
        chk("raw pt", bus1.o_plain_text, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF);

        // Empty instance, then the next beat must be taken as a key
        do_instance(128'hE0E0, 96'hE1E1, 0, 0, '0, 1'b0, 1'b0);
        do_instance(128'hBEEF, 96'hF00D, 0, 130, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0,
                    1'b1, 1'b0);

        // Abort after LEN plus one of three PT beats
        m_key = 128'hAB01; send(m_key, 1'b0, 1'b0);
        m_iv = 96'hAB02; send({m_iv, 32'h0}, 1'b0, 1'b0);
        m_size = {64'd0, 64'd384}; send(m_size, 1'b0, 1'b0);
        push_blk(1'b1, 1'b1, 128'h5555, 128'h5555);
        send(128'h5555, 1'b0, 1'b0);
        send(128'h6666, 1'b0, 1'b1);
        @(negedge clk);
        chk("abort no valid", 128'(bus0.o_valid), '0);
        chk("abort key hold", bus0.o_cipher_key, 128'hAB01);
        @(posedge clk); #1;
        do_instance(128'hC0DE, 96'hC1C1, 256, 100, 128'h89ABCDEF_01234567_FEDCBA98_76543210,
                    1'b1, 1'b0);

        // Reset mid-instance clears everything immediately
        send(128'hDEAD, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 chk("mid reset key", bus0.o_cipher_key, '0);
        chk("mid reset pt", bus0.o_plain_text, '0);
        m_aad[0] = '0; m_aad[1] = '0; m_pt[0] = '0; m_pt[1] = '0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back instances, continuous then with random gaps
        for (int g = 0; g < 2; g++) begin
            b0 = blk_cnt; n0 = new_cnt;
            do_instance(128'h1001, 96'h2001, 128, 0, 128'h3001, 1'b1, g[0]);
            do_instance(128'h1002, 96'h2002, 0, 0, '0, 1'b1, g[0]);
            do_instance(128'h1003, 96'h2003, 300, 130, 128'h3003, 1'b1, g[0]);
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("b2b new count gap=%0d", g), 128'(new_cnt - n0), 128'd3);
            if (g == 0) blk_nogap = blk_cnt - b0;
            else blk_gap = blk_cnt - b0;
        end
        chk("b2b block count", 128'(blk_nogap), 128'd7);
        chk("gap block count", 128'(blk_gap), 128'(blk_nogap));

        repeat (3) @(posedge clk);
        chk("pad queue drained", 128'(sq[0].size()), '0);
        chk("raw queue drained", 128'(sq[1].size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
